mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the instruction-fetch port and the MEM-stage data port of the RISC-V pipeline. Arbitrates requests, drives a req/ready memory handshake and returns read data. It also produces per-port busy levels; their OR is the memory_busy input of the pipeline stall controller.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-ported memory
// Optional watchdog: define ARB_TIMEOUT_EN to abort a transaction after TIMEOUT busy cycles.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_done,
    output logic                    i_busy,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_done,
    output logic                    d_busy,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic                    err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    logic [1:0] state;
    logic       last_grant;
    logic       grant_i;
    logic       grant_d;
    logic       timeout;
    logic       finish;

    // Data wins a tie unless it also won the previous grant, so fetch cannot starve.
    always_comb begin
        grant_d = d_req && (!i_req || (last_grant == GRANT_FETCH));
        grant_i = i_req && !grant_d;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (!mem_ready) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A ready arriving in the timeout cycle completes normally.
    assign timeout = (state != IDLE) && !mem_ready && (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    assign err    = timeout;
    assign finish = (state != IDLE) && (mem_ready || timeout);

    assign i_done  = (state == BUSY_I) && finish;
    assign d_done  = (state == BUSY_D) && finish;
    assign i_rdata = ((state == BUSY_I) && mem_ready) ? mem_rdata : '0;
    assign d_rdata = ((state == BUSY_D) && mem_ready) ? mem_rdata : '0;
    assign i_busy  = i_req && !i_done;
    assign d_busy  = d_req && !d_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_grant <= GRANT_FETCH;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req    <= 1'b1;
                        mem_we     <= d_we;
                        mem_be     <= d_be;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        last_grant <= GRANT_DATA;
                        state      <= BUSY_D;
                    end else if (grant_i) begin
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_be     <= '1;
                        mem_addr   <= i_addr;
                        mem_wdata  <= '0;
                        last_grant <= GRANT_FETCH;
                        state      <= BUSY_I;
                    end
                end
                default: begin
                    if (finish) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven scoreboard bench for mem_port_arbiter
// Run with ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          i_busy;
    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_busy;
    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_busy(i_busy),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_busy(d_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'h5A5A_0000) + 32'h1);
    endfunction

    // Memory responder: ready arrives wait_cfg cycles after mem_req first rises.
    int wait_cfg   = 0;
    int wcnt       = 0;
    bit mem_hang   = 1'b0;
    bit mem_manual = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!mem_manual) begin
            if (rst || !mem_req || mem_ready) begin
                mem_ready = 1'b0;
                wcnt = 0;
            end else if (!mem_hang) begin
                if (wcnt >= wait_cfg) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        int          i_n;
        int          d_n;
        logic [31:0] i_addr;
        bit          d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          wait_c;
        logic [2:0]  order;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic run_vec(input int idx, input vec_t v);
        int   d_k;
        int   i_left;
        int   d_left;
        int   cyc;
        int   total;
        bit   popped_d;
        bit   exp_i_done;
        bit   exp_d_done;
        exp_t e;
        total = v.i_n + v.d_n;
        wait_cfg = v.wait_c;
        d_k = 0;
        for (int j = 0; j < total; j++) begin
            e.is_data = v.order[j];
            e.addr    = e.is_data ? (v.d_addr + 32'(4 * d_k)) : v.i_addr;
            e.we      = e.is_data ? v.d_we : 1'b0;
            e.be      = e.is_data ? v.d_be : 4'hF;
            e.wdata   = v.d_wdata;
            e.rdata   = mem_word(e.addr);
            e.cyc     = (1 + v.wait_c) + j * (2 + v.wait_c);
            if (e.is_data) d_k++;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        i_left = v.i_n;
        d_left = v.d_n;
        d_k = 0;
        i_req = (i_left > 0);
        i_addr = v.i_addr;
        d_req = (d_left > 0);
        d_we = v.d_we;
        d_be = v.d_be;
        d_addr = v.d_addr;
        d_wdata = v.d_wdata;
        cyc = 0;
        while (sb.size() > 0 && cyc < 60) begin
            @(negedge clk);
            popped_d = 1'b0;
            e = sb[0];
            if (mem_req) begin
                check($sformatf("v%0d mem_addr c%0d", idx, cyc), mem_addr, e.addr);
                check($sformatf("v%0d mem_we c%0d", idx, cyc), 32'(mem_we), 32'(e.we));
                check($sformatf("v%0d mem_be c%0d", idx, cyc), 32'(mem_be), 32'(e.be));
                if (e.is_data && e.we)
                    check($sformatf("v%0d mem_wdata c%0d", idx, cyc), mem_wdata, e.wdata);
            end
            exp_i_done = (cyc == e.cyc) && !e.is_data;
            exp_d_done = (cyc == e.cyc) && e.is_data;
            check($sformatf("v%0d i_done c%0d", idx, cyc), 32'(i_done), 32'(exp_i_done));
            check($sformatf("v%0d d_done c%0d", idx, cyc), 32'(d_done), 32'(exp_d_done));
            check($sformatf("v%0d i_busy c%0d", idx, cyc), 32'(i_busy), 32'(i_req && !exp_i_done));
            check($sformatf("v%0d d_busy c%0d", idx, cyc), 32'(d_busy), 32'(d_req && !exp_d_done));
            if (cyc == e.cyc) begin
                check($sformatf("v%0d err c%0d", idx, cyc), 32'(err), 32'h0);
                if (e.is_data) begin
                    if (!e.we) check($sformatf("v%0d d_rdata", idx), d_rdata, e.rdata);
                    check($sformatf("v%0d i_rdata idle", idx), i_rdata, 32'h0);
                    d_left--;
                    d_k++;
                    popped_d = 1'b1;
                end else begin
                    check($sformatf("v%0d i_rdata", idx), i_rdata, e.rdata);
                    check($sformatf("v%0d d_rdata idle", idx), d_rdata, 32'h0);
                    i_left--;
                end
                void'(sb.pop_front());
            end
            @(posedge clk);
            #1;
            if (i_left == 0) i_req = 1'b0;
            if (d_left == 0) d_req = 1'b0;
            else if (popped_d) d_addr = v.d_addr + 32'(4 * d_k);
            cyc++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d completion timeout: got %0d pending expected 0", idx, sb.size());
            sb.delete();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{i_n:1, d_n:0, i_addr:32'h100, d_we:1'b0, d_be:4'h0, d_addr:32'h0,
                    d_wdata:32'h0, wait_c:1, order:3'b000};
        vecs[1] = '{i_n:1, d_n:1, i_addr:32'h104, d_we:1'b0, d_be:4'hF, d_addr:32'h200,
                    d_wdata:32'h0, wait_c:0, order:3'b001};
        vecs[2] = '{i_n:0, d_n:1, i_addr:32'h0, d_we:1'b1, d_be:4'h3, d_addr:32'h300,
                    d_wdata:32'hDEADBEEF, wait_c:3, order:3'b001};
        vecs[3] = '{i_n:1, d_n:1, i_addr:32'h108, d_we:1'b0, d_be:4'hF, d_addr:32'h210,
                    d_wdata:32'h0, wait_c:0, order:3'b010};
        vecs[4] = '{i_n:1, d_n:0, i_addr:32'h10C, d_we:1'b0, d_be:4'h0, d_addr:32'h0,
                    d_wdata:32'h0, wait_c:2, order:3'b000};
        vecs[5] = '{i_n:1, d_n:2, i_addr:32'h110, d_we:1'b0, d_be:4'hF, d_addr:32'h400,
                    d_wdata:32'h0, wait_c:1, order:3'b101};
        vecs[6] = '{i_n:1, d_n:1, i_addr:32'h114, d_we:1'b1, d_be:4'hC, d_addr:32'h500,
                    d_wdata:32'h12345678, wait_c:2, order:3'b010};

        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset mem_req", 32'(mem_req), 32'h0);
        check("reset mem_we", 32'(mem_we), 32'h0);
        check("reset mem_be", 32'(mem_be), 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset i_done", 32'(i_done), 32'h0);
        check("reset d_done", 32'(d_done), 32'h0);
        check("reset err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        // Abandon a hung load with reset, then feed a stray ready while idle.
        mem_hang = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h600;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst seq mem_req busy", 32'(mem_req), 32'h1);
        check("rst seq d_busy", 32'(d_busy), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst seq mem_req after reset", 32'(mem_req), 32'h0);
        check("rst seq d_done after reset", 32'(d_done), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_manual = 1'b1;
        mem_hang = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("stray i_done", 32'(i_done), 32'h0);
        check("stray d_done", 32'(d_done), 32'h0);
        check("stray d_rdata", d_rdata, 32'h0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_manual = 1'b0;
        @(negedge clk);
        check("stray mem_req", 32'(mem_req), 32'h0);

        mem_hang = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b1;
        i_addr = 32'h700;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("wd i_done c%0d", c), 32'(i_done), 32'(c == 4));
            check($sformatf("wd err c%0d", c), 32'(err), 32'(c == 4));
            if (c == 4) check("wd i_rdata", i_rdata, 32'h0);
            if (c >= 1) check($sformatf("wd mem_req c%0d", c), 32'(mem_req), 32'(c <= 4));
            @(posedge clk);
            #1;
            if (c == 4) i_req = 1'b0;
        end
`else
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("hang i_done c%0d", c), 32'(i_done), 32'h0);
            check($sformatf("hang err c%0d", c), 32'(err), 32'h0);
            if (c >= 1) check($sformatf("hang mem_req c%0d", c), 32'(mem_req), 32'h1);
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif
        mem_hang = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
